// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
// Provides the detector state encoding and the pattern-length clamp used
// when the run-time configuration is latched.
package seq_detect_pkg;

  // Detector state: IDLE waits for enable, FILL collects the first L bits,
  // HUNT compares every valid bit against the latched pattern.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    HUNT = 2'b10
  } state_t;

  // Clamp a requested pattern length into the legal range 1..max_len.
  function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                            input logic [31:0] max_len);
    logic [31:0] res;
    if (len == 32'd0) begin
      res = 32'd1;
    end else if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with run-time pattern and length.
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   enable         run enable; low returns the detector to IDLE
//   cfg_pattern    pattern, bit cfg_len-1 received first, bit 0 last
//   cfg_len        pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//   cfg_overlap    1 = overlapping matches allowed
//   din_valid      din is sampled only when high
//   din            serial data bit
//   clr_count      synchronous clear of match_count (wins over increment)
//   pattern_detect registered one-cycle match pulse
//   match_count    saturating match counter
//   armed          high while the detector is in HUNT
// Configuration is captured on IDLE->FILL and held until the next IDLE.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               clr_count,
  output logic               pattern_detect,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  // Compare the low len bits of a and b; upper bits are don't-care.
  function automatic logic masked_eq(input logic [MAX_LEN-1:0] a,
                                     input logic [MAX_LEN-1:0] b,
                                     input logic [LEN_W-1:0]   len);
    logic [MAX_LEN-1:0] mask;
    mask = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    return ((a ^ b) & mask) == {MAX_LEN{1'b0}};
  endfunction

  state_t             state_r,  state_next_s;
  logic [MAX_LEN-1:0] hist_r,   hist_next_s;
  logic [LEN_W-1:0]   fill_r,   fill_next_s;
  logic [MAX_LEN-1:0] pat_r,    pat_next_s;
  logic [LEN_W-1:0]   len_r,    len_next_s;
  logic               ovl_r,    ovl_next_s;
  logic               detect_r, detect_next_s;
  logic [CNT_W-1:0]   count_r,  count_next_s;
  logic               armed_r,  armed_next_s;

  logic [MAX_LEN-1:0] hist_shift_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [LEN_W-1:0]   len_clamp_s;
  logic               hit_s;

  // Datapath helpers: shifted history, saturating fill and match flag.
  always_comb begin
    hist_shift_s = {hist_r[MAX_LEN-2:0], din};
    len_clamp_s  = LEN_W'(clamp_len(32'(cfg_len), 32'(MAX_LEN)));
    if (fill_r >= len_r) begin
      fill_inc_s = len_r;
    end else begin
      fill_inc_s = fill_r + LEN_W'(1);
    end
    // A hit needs a full window of L bits since the last restart.
    hit_s = (fill_inc_s == len_r) && masked_eq(hist_shift_s, pat_r, len_r);
  end

  // Next-state, datapath and output computation.
  always_comb begin
    state_next_s  = state_r;
    hist_next_s   = hist_r;
    fill_next_s   = fill_r;
    pat_next_s    = pat_r;
    len_next_s    = len_r;
    ovl_next_s    = ovl_r;
    detect_next_s = 1'b0;
    count_next_s  = count_r;

    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next_s = FILL;
          hist_next_s  = {MAX_LEN{1'b0}};
          fill_next_s  = {LEN_W{1'b0}};
          pat_next_s   = cfg_pattern;
          len_next_s   = len_clamp_s;
          ovl_next_s   = cfg_overlap;
        end else begin
          state_next_s = IDLE;
        end
      end
      FILL, HUNT: begin
        if (!enable) begin
          // Abort: the sample on this edge is discarded.
          state_next_s = IDLE;
          hist_next_s  = {MAX_LEN{1'b0}};
          fill_next_s  = {LEN_W{1'b0}};
        end else if (din_valid) begin
          hist_next_s = hist_shift_s;
          if (hit_s) begin
            detect_next_s = 1'b1;
            if (ovl_r) begin
              state_next_s = HUNT;
              fill_next_s  = fill_inc_s;
            end else begin
              // Non-overlapping: the next match needs L fresh bits.
              state_next_s = FILL;
              fill_next_s  = {LEN_W{1'b0}};
            end
          end else begin
            fill_next_s = fill_inc_s;
            if (fill_inc_s == len_r) begin
              state_next_s = HUNT;
            end else begin
              state_next_s = FILL;
            end
          end
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        hist_next_s  = {MAX_LEN{1'b0}};
        fill_next_s  = {LEN_W{1'b0}};
      end
    endcase

    // Clear wins over a simultaneous increment; the counter never wraps.
    if (clr_count) begin
      count_next_s = {CNT_W{1'b0}};
    end else if (detect_next_s && (count_r != {CNT_W{1'b1}})) begin
      count_next_s = count_r + CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end

    armed_next_s = (state_next_s == HUNT);
  end

  // State, history, latched configuration and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      hist_r   <= {MAX_LEN{1'b0}};
      fill_r   <= {LEN_W{1'b0}};
      pat_r    <= {MAX_LEN{1'b0}};
      len_r    <= {LEN_W{1'b0}};
      ovl_r    <= 1'b0;
      detect_r <= 1'b0;
      count_r  <= {CNT_W{1'b0}};
      armed_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      hist_r   <= hist_next_s;
      fill_r   <= fill_next_s;
      pat_r    <= pat_next_s;
      len_r    <= len_next_s;
      ovl_r    <= ovl_next_s;
      detect_r <= detect_next_s;
      count_r  <= count_next_s;
      armed_r  <= armed_next_s;
    end
  end

  assign pattern_detect = detect_r;
  assign match_count    = count_r;
  assign armed          = armed_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Table-driven bench for seq_detect_param (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_param;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       din_valid;
  logic       din;
  logic       clr_count;
  logic       pattern_detect;
  logic [1:0] match_count;
  logic       armed;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       en;
    logic       dv;
    logic       d;
    logic       clr;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       det;
    logic [1:0] cnt;
    logic       arm;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] cur_pat;
  logic [3:0] cur_len;
  logic       cur_ovl;
  logic [7:0] bits;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .cfg_pattern    (cfg_pattern),
    .cfg_len        (cfg_len),
    .cfg_overlap    (cfg_overlap),
    .din_valid      (din_valid),
    .din            (din),
    .clr_count      (clr_count),
    .pattern_detect (pattern_detect),
    .match_count    (match_count),
    .armed          (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic en, input logic dv, input logic d, input logic clr,
                     input logic det, input logic [1:0] cnt, input logic arm);
    vec_t v;
    v.en = en; v.dv = dv; v.d = d; v.clr = clr;
    v.pat = cur_pat; v.len = cur_len; v.ovl = cur_ovl;
    v.det = det; v.cnt = cnt; v.arm = arm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic det, input logic [1:0] cnt, input logic arm);
    check("pattern_detect", idx, 8'(pattern_detect), 8'(det));
    check("match_count", idx, 8'(match_count), 8'(cnt));
    check("armed", idx, 8'(armed), 8'(arm));
  endtask

  task automatic apply(input vec_t v, input int idx);
    enable      = v.en;
    din_valid   = v.dv;
    din         = v.d;
    clr_count   = v.clr;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ovl;
    @(posedge clk);
    #1;
    check_outs(idx, v.det, v.cnt, v.arm);
  endtask

  task automatic run_table(input int base);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], base + i);
    end
    vecs.delete();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; din_valid = 1'b0; din = 1'b0; clr_count = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    #12;
    check_outs(0, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;

    // 1: L=3 "101", non-overlapping: single pulse after bit 3
    cur_pat = 8'h05; cur_len = 4'd3; cur_ovl = 1'b0;
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

    // 2: same stream, overlapping: pulses after bits 3 and 5, armed from bit 3
    cur_ovl = 1'b1;
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);

    // 3: L=8 0xA5 with a din_valid gap (carrying the wrong bit) after every bit
    cur_pat = 8'hA5; cur_len = 4'd8; cur_ovl = 1'b0; bits = 8'hA5;
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      add(1'b1, 1'b1, bits[i], 1'b0, (i == 0), (i == 0) ? 2'd1 : 2'd0, 1'b0);
      add(1'b1, 1'b0, ~bits[i], 1'b0, 1'b0, (i == 0) ? 2'd1 : 2'd0, 1'b0);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

    // 4: L=1 pattern 1, overlapping, continuous 1s: saturation and clear priority
    cur_pat = 8'h01; cur_len = 4'd1; cur_ovl = 1'b1;
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

    // 5a: cfg_len=0 behaves as L=1 (pattern bit0 = 0)
    cur_pat = 8'h00; cur_len = 4'd0; cur_ovl = 1'b1;
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);

    // 5b: cfg_len=15 behaves as L=8; config edits while enabled are ignored
    cur_pat = 8'h3C; cur_len = 4'd15; cur_ovl = 1'b0; bits = 8'h3C;
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    cur_pat = 8'h00; cur_len = 4'd2; cur_ovl = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      add(1'b1, 1'b1, bits[i], 1'b0, (i == 0), (i == 0) ? 2'd1 : 2'd0, 1'b0);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);

    // 6b: enable dropped after 2 of 3 bits of "001"; fill must restart
    cur_pat = 8'h01; cur_len = 4'd3; cur_ovl = 1'b0;
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    run_table(1);

    // 6a: asynchronous reset while outputs are active, then a full restart
    cur_pat = 8'h05; cur_len = 4'd3; cur_ovl = 1'b1;
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    run_table(1000);
    #2;
    reset_n = 1'b0;
    #1;
    check_outs(2000, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    run_table(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
